// File: rtl/dmem_byte_bank_ctrl.sv
// rtl/dmem_byte_bank_ctrl.sv - LSU front end for four byte-lane data-memory banks
module dmem_byte_bank_ctrl #(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 16,
    parameter int CNT_W            = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [2:0]              req_funct3_i,
    input  logic [31:0]             req_addr_i,
    input  logic [31:0]             req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [4*(ADDR_W-2)-1:0] bank_addr_o,
    output logic [3:0]              bank_wren_o,
    output logic [31:0]             bank_wdata_o,
    input  logic [31:0]             bank_rdata_i,
    output logic [CNT_W-1:0]        cnt_load_o,
    output logic [CNT_W-1:0]        cnt_store_o,
    output logic [CNT_W-1:0]        cnt_misal_o
);
    localparam int ROW_W = ADDR_W - 2;

    logic [ROW_W-1:0] row;
    logic [1:0]       off;
    logic [1:0]       lane;
    logic             legal;
    logic             misal;
    logic             err;
    logic             fire;
    logic [31:0]      gath;
    logic [31:0]      ext;
    logic [31:0]      load_data;
    logic             unused_addr;

    assign row         = req_addr_i[ADDR_W-1:2];
    assign off         = req_addr_i[1:0];
    assign unused_addr = ^req_addr_i[31:ADDR_W];

    always_comb begin
        case (req_funct3_i)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
    end

    assign misal = legal & (((req_funct3_i[1:0] == 2'b01) & off[0]) |
                            ((req_funct3_i[1:0] == 2'b10) & (off != 2'b00)));
    assign err   = !legal | (misal & (ALLOW_MISALIGNED == 1'b0));

    assign req_ready_o = !rsp_valid_o | rsp_ready_i;
    assign fire        = req_valid_i & req_ready_o & !rst_i;

    // Byte i of the access lives in bank (off + i) mod 4, so bank b carries lane (b - off) mod 4.
    always_comb begin
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_wren_o  = '0;
        gath         = '0;
        lane         = '0;
        for (int b = 0; b < 4; b++) begin
            lane = 2'(b) - off;
            bank_addr_o[b*ROW_W +: ROW_W] = (2'(b) < off) ? row + ROW_W'(1) : row;
            bank_wdata_o[8*b +: 8]        = req_wdata_i[8*lane +: 8];
            gath[8*lane +: 8]             = bank_rdata_i[8*b +: 8];
            case (req_funct3_i[1:0])
                2'b00:   bank_wren_o[b] = fire & req_we_i & !err & (lane == 2'd0);
                2'b01:   bank_wren_o[b] = fire & req_we_i & !err & !lane[1];
                2'b10:   bank_wren_o[b] = fire & req_we_i & !err;
                default: bank_wren_o[b] = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (req_funct3_i)
            3'b000:  ext = {{24{gath[7]}}, gath[7:0]};
            3'b100:  ext = {24'd0, gath[7:0]};
            3'b001:  ext = {{16{gath[15]}}, gath[15:0]};
            3'b101:  ext = {16'd0, gath[15:0]};
            default: ext = gath;
        endcase
        load_data = (req_we_i | err) ? 32'd0 : ext;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            cnt_load_o  <= '0;
            cnt_store_o <= '0;
            cnt_misal_o <= '0;
        end else begin
            if (fire) begin
                rsp_valid_o <= 1'b1;
                rsp_rdata_o <= load_data;
                rsp_err_o   <= err;
            end else if (rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
            if (fire && !req_we_i && !(&cnt_load_o))
                cnt_load_o <= cnt_load_o + CNT_W'(1);
            if (fire && req_we_i && !(&cnt_store_o))
                cnt_store_o <= cnt_store_o + CNT_W'(1);
            if (fire && misal && !(&cnt_misal_o))
                cnt_misal_o <= cnt_misal_o + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_dmem_byte_bank_ctrl.sv
// tb/tb_dmem_byte_bank_ctrl.sv - directed vector bench for dmem_byte_bank_ctrl
module tb_dmem_byte_bank_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, rsp_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, bank_wdata, bank_rdata;
    logic [55:0] bank_addr;
    logic [3:0]  bank_wren;
    logic [15:0] cnt_load, cnt_store, cnt_misal;

    logic        req_valid2, req_we2, rsp_ready2;
    logic [2:0]  req_funct32;
    logic [31:0] req_addr2, req_wdata2;
    logic        req_ready2, rsp_valid2, rsp_err2;
    logic [31:0] rsp_rdata2, bank_wdata2;
    logic [55:0] bank_addr2;
    logic [3:0]  bank_wren2;
    logic [15:0] cnt_load2, cnt_store2, cnt_misal2;

    logic [7:0]  mem [4][16384];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_byte_bank_ctrl #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(16), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .bank_addr_o(bank_addr),
        .bank_wren_o(bank_wren), .bank_wdata_o(bank_wdata), .bank_rdata_i(bank_rdata),
        .cnt_load_o(cnt_load), .cnt_store_o(cnt_store), .cnt_misal_o(cnt_misal)
    );

    dmem_byte_bank_ctrl #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(16), .CNT_W(16)) dut2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid2), .req_ready_o(req_ready2),
        .req_we_i(req_we2), .req_funct3_i(req_funct32), .req_addr_i(req_addr2),
        .req_wdata_i(req_wdata2), .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2),
        .rsp_rdata_o(rsp_rdata2), .rsp_err_o(rsp_err2), .bank_addr_o(bank_addr2),
        .bank_wren_o(bank_wren2), .bank_wdata_o(bank_wdata2), .bank_rdata_i(32'hA5A5A5A5),
        .cnt_load_o(cnt_load2), .cnt_store_o(cnt_store2), .cnt_misal_o(cnt_misal2)
    );

    initial begin
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 16384; r++)
                mem[b][r] = 8'h00;
    end

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bank_wren[b]) mem[b][bank_addr[14*b +: 14]] <= bank_wdata[8*b +: 8];
    end

    always_comb begin
        bank_rdata = '0;
        for (int b = 0; b < 4; b++)
            bank_rdata[8*b +: 8] = mem[b][bank_addr[14*b +: 14]];
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wren;
        logic [55:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vt[15];

    function automatic logic [55:0] rows(input logic [13:0] r0, r1, r2, r3);
        return {r3, r2, r1, r0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vt[0]  = '{1'b1, 3'b010, 32'h00000100, 32'hDEADBEEF, 4'hF, rows(14'h40, 14'h40, 14'h40, 14'h40), 32'hDEADBEEF, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 3'b010, 32'h00000100, 32'h0, 4'h0, rows(14'h40, 14'h40, 14'h40, 14'h40), 32'h0, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 3'b000, 32'h00000203, 32'h00000080, 4'h8, rows(14'h81, 14'h81, 14'h81, 14'h80), 32'h80000000, 32'h0, 1'b0};
        vt[3]  = '{1'b0, 3'b000, 32'h00000203, 32'h0, 4'h0, rows(14'h81, 14'h81, 14'h81, 14'h80), 32'h0, 32'hFFFFFF80, 1'b0};
        vt[4]  = '{1'b0, 3'b100, 32'h00000203, 32'h0, 4'h0, rows(14'h81, 14'h81, 14'h81, 14'h80), 32'h0, 32'h00000080, 1'b0};
        vt[5]  = '{1'b1, 3'b010, 32'h00000006, 32'h11223344, 4'hF, rows(14'h2, 14'h2, 14'h1, 14'h1), 32'h33441122, 32'h0, 1'b0};
        vt[6]  = '{1'b0, 3'b010, 32'h00000006, 32'h0, 4'h0, rows(14'h2, 14'h2, 14'h1, 14'h1), 32'h0, 32'h11223344, 1'b0};
        vt[7]  = '{1'b1, 3'b010, 32'hABCDFFFF, 32'hCAFEF00D, 4'hF, rows(14'h0, 14'h0, 14'h0, 14'h3FFF), 32'h0DCAFEF0, 32'h0, 1'b0};
        vt[8]  = '{1'b0, 3'b010, 32'h0000FFFF, 32'h0, 4'h0, rows(14'h0, 14'h0, 14'h0, 14'h3FFF), 32'h0, 32'hCAFEF00D, 1'b0};
        vt[9]  = '{1'b0, 3'b001, 32'h00000102, 32'h0, 4'h0, rows(14'h41, 14'h41, 14'h40, 14'h40), 32'h0, 32'hFFFFDEAD, 1'b0};
        vt[10] = '{1'b0, 3'b101, 32'h00000102, 32'h0, 4'h0, rows(14'h41, 14'h41, 14'h40, 14'h40), 32'h0, 32'h0000DEAD, 1'b0};
        vt[11] = '{1'b0, 3'b001, 32'h00000103, 32'h0, 4'h0, rows(14'h41, 14'h41, 14'h41, 14'h40), 32'h0, 32'h000000DE, 1'b0};
        vt[12] = '{1'b1, 3'b011, 32'h00000100, 32'h12345678, 4'h0, rows(14'h40, 14'h40, 14'h40, 14'h40), 32'h12345678, 32'h0, 1'b1};
        vt[13] = '{1'b0, 3'b010, 32'h00000100, 32'h0, 4'h0, rows(14'h40, 14'h40, 14'h40, 14'h40), 32'h0, 32'hDEADBEEF, 1'b0};
        vt[14] = '{1'b1, 3'b001, 32'h00000001, 32'h0000BEEF, 4'h6, rows(14'h1, 14'h0, 14'h0, 14'h0), 32'h00BEEF00, 32'h0, 1'b0};

        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'h55555555;
        rsp_ready = 1'b1;
        req_valid2 = 1'b0; req_we2 = 1'b0; req_funct32 = 3'b010; req_addr2 = 32'h0; req_wdata2 = 32'h0;
        rsp_ready2 = 1'b1;
        #1 check("wren_in_reset", 64'(bank_wren), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
        check("rst_req_ready", 64'(req_ready), 64'h1);
        check("rst_cnt_load", 64'(cnt_load), 64'h0);
        check("rst_cnt_store", 64'(cnt_store), 64'h0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = vt[i].we; req_funct3 = vt[i].f3;
            req_addr = vt[i].addr; req_wdata = vt[i].wdata;
            #1;
            check($sformatf("v%0d_wren", i), 64'(bank_wren), 64'(vt[i].wren));
            check($sformatf("v%0d_baddr", i), 64'(bank_addr), 64'(vt[i].baddr));
            if (vt[i].we) check($sformatf("v%0d_bwdata", i), 64'(bank_wdata), 64'(vt[i].bwdata));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'h1);
            check($sformatf("v%0d_rsp_rdata", i), 64'(rsp_rdata), 64'(vt[i].rdata));
            check($sformatf("v%0d_rsp_err", i), 64'(rsp_err), 64'(vt[i].err));
        end
        check("cnt_load", 64'(cnt_load), 64'd9);
        check("cnt_store", 64'(cnt_store), 64'd6);
        check("cnt_misal", 64'(cnt_misal), 64'd6);

        // Drain, then stall the response for three cycles with a new request waiting.
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("drain_rsp_valid", 64'(rsp_valid), 64'h0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; rsp_ready = 1'b0;
        #1 check("stall_pre_ready", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        check("stall_first_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        @(negedge clk);
        req_funct3 = 3'b100; req_addr = 32'h203;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_req_ready", c), 64'(req_ready), 64'h0);
            check($sformatf("stall%0d_rsp_valid", c), 64'(rsp_valid), 64'h1);
            check($sformatf("stall%0d_rsp_rdata", c), 64'(rsp_rdata), 64'hDEADBEEF);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1 check("release_req_ready", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        check("release_rsp_valid", 64'(rsp_valid), 64'h1);
        check("release_rsp_rdata", 64'(rsp_rdata), 64'h00000080);
        check("release_cnt_load", 64'(cnt_load), 64'd11);

        // Reset while stalled with a store waiting: store dropped, response discarded.
        @(negedge clk);
        rsp_ready = 1'b0; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'h0;
        @(posedge clk); #1;
        check("stall2_rsp_rdata", 64'(rsp_rdata), 64'h00000080);
        @(negedge clk);
        rst = 1'b1; rsp_ready = 1'b1;
        #1 check("rst_mid_wren", 64'(bank_wren), 64'h0);
        @(posedge clk); #1;
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_mid_cnt_load", 64'(cnt_load), 64'h0);
        check("rst_mid_cnt_store", 64'(cnt_store), 64'h0);
        check("rst_mid_cnt_misal", 64'(cnt_misal), 64'h0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        check("post_rst_req_ready", 64'(req_ready), 64'h1);
        check("store_dropped_b0", 64'(mem[0][14'h40]), 64'hEF);
        check("store_dropped_b3", 64'(mem[3][14'h40]), 64'hDE);

        // Misaligned disallowed on the second instance.
        req_valid2 = 1'b1; req_we2 = 1'b1; req_funct32 = 3'b001; req_addr2 = 32'h1; req_wdata2 = 32'hBEEF;
        #1 check("d2_sh_wren", 64'(bank_wren2), 64'h0);
        @(posedge clk); #1;
        check("d2_sh_err", 64'(rsp_err2), 64'h1);
        check("d2_sh_rdata", 64'(rsp_rdata2), 64'h0);
        @(negedge clk);
        req_we2 = 1'b0; req_funct32 = 3'b011; req_addr2 = 32'h0;
        @(posedge clk); #1;
        check("d2_ill_err", 64'(rsp_err2), 64'h1);
        check("d2_ill_rdata", 64'(rsp_rdata2), 64'h0);
        @(negedge clk);
        req_funct32 = 3'b100;
        @(posedge clk); #1;
        check("d2_lbu_err", 64'(rsp_err2), 64'h0);
        check("d2_lbu_rdata", 64'(rsp_rdata2), 64'h000000A5);
        @(negedge clk);
        req_valid2 = 1'b0;
        check("d2_cnt_store", 64'(cnt_store2), 64'd1);
        check("d2_cnt_load", 64'(cnt_load2), 64'd2);
        check("d2_cnt_misal", 64'(cnt_misal2), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_byte_bank_ctrl.md
Name: dmem_byte_bank_ctrl

Overview:
Load/store front end that drives four byte-wide 16K-entry data-memory banks (bank b holds byte lane b) from the pipeline's LSU request.
- Splits each request into per-bank row address, write enable and write byte.
- Gathers and rotates the bank read bytes, then sign- or zero-extends them.
- Returns a registered response over a valid/ready handshake.
- Handles misaligned accesses in a single bank cycle by giving each bank its own row address.
- Keeps saturating access counters for debug.

Parameters:
ALLOW_MISALIGNED, 1, 1: misaligned half/word accesses are performed; 0: they return an error and perform no write.
ADDR_W, 16, byte address bits used (4 banks x 16K bytes = 64 KiB).
CNT_W, 16, width of each saturating performance counter.

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  LSU request valid
req_ready_o  out  1  request accepted when req_valid_i & req_ready_o
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal
req_addr_i  in  32  byte address; bits above ADDR_W-1 are ignored
req_wdata_i  in  32  store data, right-aligned
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when rsp_valid_o & rsp_ready_i
rsp_rdata_o  out  32  extended load data; 0 for stores and errors
rsp_err_o  out  1  illegal funct3, or misaligned with ALLOW_MISALIGNED=0
bank_addr_o  out  56  4 x 14-bit row address; bank b occupies bits [14b+13:14b]
bank_wren_o  out  4  per-bank write enable
bank_wdata_o  out  32  bank b write byte at bits [8b+7:8b]
bank_rdata_i  in  32  bank b combinational read byte at bits [8b+7:8b]
cnt_load_o  out  CNT_W  count of accepted loads, saturating
cnt_store_o  out  CNT_W  count of accepted stores, saturating
cnt_misal_o  out  CNT_W  count of accepted misaligned accesses, saturating

Behaviour:
- Address decode: row = addr[ADDR_W-1:2], off = addr[1:0], size = 1, 2 or 4 bytes from funct3[1:0].
- Misaligned means: H with off[0] = 1, or W with off != 0.
- Bank row: bank_addr[b] = row + 1 if b < off, else row. The +1 wraps modulo 16K, so address 0xFFFF W touches row 0x3FFF of bank 3 and row 0 of banks 0..2.
- Lane mapping: byte i of the access (i < size) maps to bank (off + i) mod 4.
  - bank_wdata byte = req_wdata byte i.
  - bank_wren[b] = fire & we & lane active & no error.
  - bank_addr and bank_wdata are driven combinationally every cycle, including when not firing.
- Load gather: byte i = bank_rdata lane (off + i) mod 4. B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
- Handshake:
  - req_ready_o = !rsp_valid_o | rsp_ready_i.
  - On fire, the write is performed in the same cycle, and the response register loads rdata/err with rsp_valid_o = 1 on the next edge: 1-cycle latency.
  - rsp_valid_o, rsp_rdata_o and rsp_err_o hold stable while rsp_valid_o & !rsp_ready_i.
  - Back-to-back requests give one response per cycle when rsp_ready_i = 1.
  - rsp_valid_o clears when consumed and no new fire occurs in that cycle.
- Error cases:
  - Illegal funct3: err = 1, no bank write, rdata = 0.
  - Misaligned with ALLOW_MISALIGNED = 0: same as illegal funct3.
  - Misaligned is still counted in cnt_misal_o even when it errors.
- Counters: on each fire, cnt_load_o or cnt_store_o increments. Each counter holds at all-ones once saturated; error requests are counted too.
- Reset (rst_i = 1 at an edge):
  - rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, all counters = 0.
  - req_ready_o = 1 from the following cycle.
  - bank_wren_o = 0 while rst_i is high, even if req_valid_i is high.
  - A request presented during reset is dropped; a pending response is discarded.

Test Plan:
- SW addr 0x0100 wdata 0xDEADBEEF then LW 0x0100 -> bank_wren = 4'b1111 with all rows 0x0040; response 0xDEADBEEF one cycle after fire, err = 0.
- SB 0x0203 data 0x80 then LB 0x0203 / LBU 0x0203 -> bank_wren = 4'b1000; rdata 0xFFFFFF80 / 0x00000080.
- SW 0x0006 data 0x11223344 (ALLOW_MISALIGNED=1) -> banks 2,3 row 1 get 0x44,0x33 and banks 0,1 row 2 get 0x22,0x11; LW 0x0006 returns 0x11223344; cnt_misal = 2.
- LW 0xFFFF -> bank 3 row 0x3FFF, banks 0..2 row 0 (wrap).
- ALLOW_MISALIGNED=0 with SH 0x0001, then funct3 = 3'b011 -> both give rsp_err = 1, bank_wren = 0, rdata = 0.
- Hold rsp_ready_i = 0 for 3 cycles with req_valid_i high -> req_ready = 0 and the response is stable throughout. Release -> next request fires the same cycle. Assert rst_i mid-stall -> rsp_valid = 0 and counters = 0 next cycle.
